// File: rtl/ddr2_dram_pipe.sv
// Behavioural DDR2 DRAM device model with bank open/close tracking,
// CL-delayed burst read/write pipelines, byte masking and protocol errors.
module ddr2_dram_pipe #(
  parameter int DQ_WIDTH   = 16,
  parameter int BANK_BITS  = 2,
  parameter int ROW_BITS   = 4,
  parameter int COL_BITS   = 6,
  parameter int ADDR_WIDTH = 13,
  parameter int CL         = 3,
  parameter int BL         = 4
) (
  input  logic                  ck,
  input  logic                  reset,
  input  logic                  cke,
  input  logic                  cs_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [BANK_BITS-1:0]  ba,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DQ_WIDTH-1:0]   dq_in,
  input  logic [DQ_WIDTH/8-1:0] dm,
  output logic [DQ_WIDTH-1:0]   dq_out,
  output logic                  dq_oe,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic [7:0]            err_count
);

  localparam int NB    = 1 << BANK_BITS;
  localparam int NL    = DQ_WIDTH / 8;
  localparam int LB    = $clog2(BL);
  localparam int AW    = BANK_BITS + ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << AW;

  // Latched access: everything a burst needs, so later PRE/ACT cannot disturb it
  typedef struct packed {
    logic                 vld;
    logic [BANK_BITS-1:0] bank;
    logic [ROW_BITS-1:0]  row;
    logic [COL_BITS-1:0]  col;
  } acc_t;

  // Flat storage index for beat k: low column bits wrap within the burst
  function automatic logic [AW-1:0] beat_idx(acc_t a, logic [LB-1:0] k);
    logic [COL_BITS-1:0] c;
    c         = a.col;
    c[LB-1:0] = a.col[LB-1:0] + k;
    return {a.bank, a.row, c};
  endfunction

  // Storage and per-location written flags
  logic [DQ_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]    wr_bit_q;

  // Bank state
  logic                cke_prev_q;
  logic [NB-1:0]       open_q;
  logic [ROW_BITS-1:0] row_q [NB];

  // Data bus turnaround tracking: edges since the last accepted RD/WR
  logic [3:0] gap_q;
  logic       last_rd_q;

  logic       err_valid_q;
  logic [1:0] err_code_q;
  logic [7:0] err_count_q;

  logic       cmd_en, is_act, is_rd, is_wr, is_pre;
  logic       bank_open, conflict, rd_acc, wr_acc;
  logic [1:0] err_d;
  acc_t       new_acc;

  // Only the bits actually decoded are consumed; the rest of addr is don't-care
  logic unused_addr;
  assign unused_addr = ^addr;

  // Command decode, legality checks and error classification
  always_comb begin
    cmd_en    = cke && cke_prev_q && !cs_n;
    is_act    = cmd_en && ({ras_n, cas_n, we_n} == 3'b011);
    is_rd     = cmd_en && ({ras_n, cas_n, we_n} == 3'b101);
    is_wr     = cmd_en && ({ras_n, cas_n, we_n} == 3'b100);
    is_pre    = cmd_en && ({ras_n, cas_n, we_n} == 3'b010);
    bank_open = open_q[ba];
    conflict  = (gap_q < 4'(BL)) || (is_wr && last_rd_q && (gap_q < 4'(BL + 1)));
    err_d     = 2'b00;
    if (is_act && bank_open)                      err_d = 2'b01;
    else if ((is_rd || is_wr) && !bank_open)      err_d = 2'b10;
    else if ((is_rd || is_wr) && conflict)        err_d = 2'b11;
    rd_acc       = is_rd && bank_open && !conflict;
    wr_acc       = is_wr && bank_open && !conflict;
    new_acc.vld  = 1'b1;
    new_acc.bank = ba;
    new_acc.row  = row_q[ba];
    new_acc.col  = addr[COL_BITS-1:0];
  end

  // Bank open/close and open-row latch
  always_ff @(posedge ck) begin
    if (reset) begin
      open_q <= '0;
    end else if (is_act && !open_q[ba]) begin
      open_q[ba] <= 1'b1;
      row_q[ba]  <= addr[ROW_BITS-1:0];
    end else if (is_pre) begin
      if (addr[10]) open_q     <= '0;
      else          open_q[ba] <= 1'b0;
    end
  end

  // CKE history, bus gap counter and error reporting
  always_ff @(posedge ck) begin
    if (reset) begin
      cke_prev_q  <= 1'b0;
      gap_q       <= '1;
      last_rd_q   <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
      err_count_q <= 8'd0;
    end else begin
      cke_prev_q <= cke;
      if (rd_acc || wr_acc) begin
        gap_q     <= 4'd1;
        last_rd_q <= rd_acc;
      end else if (gap_q != 4'hF) begin
        gap_q <= gap_q + 4'd1;
      end
      err_valid_q <= (err_d != 2'b00);
      err_code_q  <= err_d;
      if ((err_d != 2'b00) && (err_count_q != 8'hFF))
        err_count_q <= err_count_q + 8'd1;
    end
  end

  // ---------------- read path ----------------
  acc_t                rd_dly_q [CL];
  acc_t                rb_q;
  logic [LB-1:0]       rb_beat_q;
  logic [DQ_WIDTH-1:0] dq_out_q;
  logic                dq_oe_q;

  logic                rd_start;
  acc_t                rd_sel;
  logic [LB-1:0]       rd_k;
  logic [AW-1:0]       rd_idx;
  logic [DQ_WIDTH-1:0] rd_word;

  // Select the beat to drive this edge; unwritten locations read as zero
  always_comb begin
    rd_start = rd_dly_q[CL-1].vld;
    rd_sel   = rd_start ? rd_dly_q[CL-1] : rb_q;
    rd_k     = rd_start ? '0 : rb_beat_q;
    rd_idx   = beat_idx(rd_sel, rd_k);
    rd_word  = wr_bit_q[rd_idx] ? mem_q[rd_idx] : '0;
  end

  // CL delay line then burst engine; a new burst may start on the edge the old one ends
  always_ff @(posedge ck) begin
    if (reset) begin
      for (int i = 0; i < CL; i++) rd_dly_q[i] <= '0;
      rb_q      <= '0;
      rb_beat_q <= '0;
      dq_out_q  <= '0;
      dq_oe_q   <= 1'b0;
    end else begin
      rd_dly_q[0] <= rd_acc ? new_acc : '0;
      for (int i = 1; i < CL; i++) rd_dly_q[i] <= rd_dly_q[i-1];
      if (rd_start || rb_q.vld) begin
        dq_out_q <= rd_word;
        dq_oe_q  <= 1'b1;
        if (rd_start) begin
          rb_q      <= rd_dly_q[CL-1];
          rb_beat_q <= LB'(1);
        end else begin
          rb_beat_q <= rb_beat_q + LB'(1);
          if (rb_beat_q == LB'(BL - 1)) rb_q.vld <= 1'b0;
        end
      end else begin
        dq_out_q <= '0;
        dq_oe_q  <= 1'b0;
      end
    end
  end

  // ---------------- write path ----------------
  acc_t          wr_dly_q [CL-1];
  acc_t          wb_q;
  logic [LB-1:0] wb_beat_q;

  logic          wr_start, wr_en;
  acc_t          wr_sel;
  logic [LB-1:0] wr_k;
  logic [AW-1:0] wr_idx;

  // Write beats are captured one edge earlier than read beats are driven
  always_comb begin
    wr_start = wr_dly_q[CL-2].vld;
    wr_en    = wr_start || wb_q.vld;
    wr_sel   = wr_start ? wr_dly_q[CL-2] : wb_q;
    wr_k     = wr_start ? '0 : wb_beat_q;
    wr_idx   = beat_idx(wr_sel, wr_k);
  end

  // CL-1 delay line then write burst engine
  always_ff @(posedge ck) begin
    if (reset) begin
      for (int i = 0; i < CL - 1; i++) wr_dly_q[i] <= '0;
      wb_q      <= '0;
      wb_beat_q <= '0;
    end else begin
      wr_dly_q[0] <= wr_acc ? new_acc : '0;
      for (int i = 1; i < CL - 1; i++) wr_dly_q[i] <= wr_dly_q[i-1];
      if (wr_start) begin
        wb_q      <= wr_dly_q[CL-2];
        wb_beat_q <= LB'(1);
      end else if (wb_q.vld) begin
        wb_beat_q <= wb_beat_q + LB'(1);
        if (wb_beat_q == LB'(BL - 1)) wb_q.vld <= 1'b0;
      end
    end
  end

  // Byte-masked storage update; contents survive reset, only the flags are cleared
  always_ff @(posedge ck) begin
    if (!reset && wr_en) begin
      for (int l = 0; l < NL; l++)
        if (!dm[l]) mem_q[wr_idx][l*8 +: 8] <= dq_in[l*8 +: 8];
    end
  end

  // Written flags: set when any byte lane of a beat lands
  always_ff @(posedge ck) begin
    if (reset)                 wr_bit_q         <= '0;
    else if (wr_en && !(&dm))  wr_bit_q[wr_idx] <= 1'b1;
  end

  assign dq_out    = dq_out_q;
  assign dq_oe     = dq_oe_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_ddr2_dram_pipe.sv
// Directed bench for ddr2_dram_pipe at CL=3, BL=4, DQ_WIDTH=16.
module tb_ddr2_dram_pipe;

  localparam logic [2:0] K_NOP = 3'd0, K_ACT = 3'd1, K_RD = 3'd2, K_WR = 3'd3, K_PRE = 3'd4;
  localparam int NV = 43;

  logic        ck, reset, cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic [15:0] dq_in;
  logic [1:0]  dm;
  logic [15:0] dq_out;
  logic        dq_oe, err_valid;
  logic [1:0]  err_code;
  logic [7:0]  err_count;

  int tests, fails;

  ddr2_dram_pipe #(.DQ_WIDTH(16), .BANK_BITS(2), .ROW_BITS(4), .COL_BITS(6),
                   .ADDR_WIDTH(13), .CL(3), .BL(4)) dut (
    .ck(ck), .reset(reset), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .addr(addr), .dq_in(dq_in), .dm(dm), .dq_out(dq_out),
    .dq_oe(dq_oe), .err_valid(err_valid), .err_code(err_code), .err_count(err_count));

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  typedef struct {
    logic [2:0]  k;
    logic [1:0]  b;
    logic [12:0] a;
    logic [15:0] d;
    logic [1:0]  m;
    logic        eoe;
    logic [15:0] edq;
    logic        eev;
    logic [1:0]  ecode;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t tv [NV];

  task automatic drive(input logic [2:0] k, input logic [1:0] b, input logic [12:0] a);
    ba = b;
    addr = a;
    case (k)
      K_ACT:   {cs_n, ras_n, cas_n, we_n} = 4'b0011;
      K_RD:    {cs_n, ras_n, cas_n, we_n} = 4'b0101;
      K_WR:    {cs_n, ras_n, cas_n, we_n} = 4'b0100;
      K_PRE:   {cs_n, ras_n, cas_n, we_n} = 4'b0010;
      default: {cs_n, ras_n, cas_n, we_n} = 4'b1111;
    endcase
  endtask

  // Apply a command for one edge and sample 1 time unit after it
  task automatic step(input logic [2:0] k, input logic [1:0] b, input logic [12:0] a);
    drive(k, b, a);
    @(posedge ck);
    #1;
    drive(K_NOP, 2'd0, 13'd0);
  endtask

  task automatic chk(input string name, input logic oe, input logic [15:0] q,
                     input logic ev, input logic [1:0] code, input logic [7:0] cnt);
    tests++;
    if (dq_oe !== oe || dq_out !== q || err_valid !== ev || err_code !== code || err_count !== cnt) begin
      fails++;
      $display("FAIL %s: got oe=%0b dq=%h ev=%0b code=%b cnt=%0d, expected oe=%0b dq=%h ev=%0b code=%b cnt=%0d",
               name, dq_oe, dq_out, err_valid, err_code, err_count, oe, q, ev, code, cnt);
    end
  endtask

  task automatic sc(input int i, input logic [2:0] k, input logic [1:0] b, input logic [12:0] a);
    tv[i].k = k; tv[i].b = b; tv[i].a = a;
  endtask
  task automatic sd(input int i, input logic [15:0] d, input logic [1:0] m);
    tv[i].d = d; tv[i].m = m;
  endtask
  task automatic so(input int i, input logic [15:0] q);
    tv[i].eoe = 1'b1; tv[i].edq = q;
  endtask
  task automatic se(input int i, input logic [1:0] c);
    tv[i].eev = 1'b1; tv[i].ecode = c;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    cke   = 1'b1;
    dq_in = '0;
    dm    = '0;
    drive(K_NOP, 2'd0, 13'd0);

    // ---- vector table ----
    for (int i = 0; i < NV; i++) begin
      tv[i] = '{k: K_NOP, b: 2'd0, a: 13'd0, d: 16'h0, m: 2'b00,
                eoe: 1'b0, edq: 16'h0, eev: 1'b0, ecode: 2'b00,
                ecnt: (i >= 41) ? 8'd4 : (i >= 39) ? 8'd3 : (i >= 37) ? 8'd2 : (i >= 35) ? 8'd1 : 8'd0};
    end
    sc(0, K_ACT, 1, 5);                    // cke_prev still 0: ignored, no error
    sc(1, K_ACT, 1, 5);                    // accepted (would be err 01 if row 0 had opened it)
    sc(2, K_WR, 1, 8);                     // beats captured at edges 4..7
    sd(4, 16'h1111, 2'b00); sd(5, 16'h2222, 2'b00);
    sd(6, 16'h3333, 2'b00); sd(7, 16'h4444, 2'b00);
    sc(8, K_RD, 1, 8);                     // beats after edges 11..14
    so(11, 16'h1111); so(12, 16'h2222); so(13, 16'h3333); so(14, 16'h4444);
    sc(15, K_RD, 1, 10);                   // wrap: 10,11,8,9
    so(18, 16'h3333); so(19, 16'h4444); so(20, 16'h1111); so(21, 16'h2222);
    sc(22, K_WR, 1, 8);                    // beat0 masked upper byte, others fully masked
    sd(24, 16'hABCD, 2'b10);
    sd(25, 16'hFFFF, 2'b11); sd(26, 16'hFFFF, 2'b11); sd(27, 16'hFFFF, 2'b11);
    sc(28, K_RD, 1, 8);
    so(31, 16'h11CD); so(32, 16'h2222); so(33, 16'h3333); so(34, 16'h4444);
    sc(35, K_RD, 2, 0);  se(35, 2'b10);    // closed bank
    sc(37, K_ACT, 1, 7); se(37, 2'b01);    // already open
    sc(39, K_WR, 2, 0);  se(39, 2'b10);
    sc(40, K_PRE, 0, 13'h400);             // precharge all
    sc(41, K_RD, 1, 8);  se(41, 2'b10);

    // ---- reset state ----
    repeat (2) @(posedge ck);
    #1;
    chk("reset_state", 1'b0, 16'h0, 1'b0, 2'b00, 8'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      dq_in = tv[i].d;
      dm    = tv[i].m;
      step(tv[i].k, tv[i].b, tv[i].a);
      chk($sformatf("vec%0d", i), tv[i].eoe, tv[i].edq, tv[i].eev, tv[i].ecode, tv[i].ecnt);
    end
    dq_in = '0;
    dm    = '0;

    // ---- back-to-back reads, too-early RD, and WR turnaround after RD ----
    step(K_ACT, 1, 5);  chk("sA_act", 1'b0, 16'h0, 1'b0, 2'b00, 8'd4);
    step(K_NOP, 0, 0);  chk("sA_nop", 1'b0, 16'h0, 1'b0, 2'b00, 8'd4);
    step(K_RD, 1, 8);   chk("sA_t0", 1'b0, 16'h0, 1'b0, 2'b00, 8'd4);
    step(K_NOP, 0, 0);  chk("sA_t1", 1'b0, 16'h0, 1'b0, 2'b00, 8'd4);
    step(K_RD, 1, 12);  chk("sA_t2_conflict", 1'b0, 16'h0, 1'b1, 2'b11, 8'd5);
    step(K_NOP, 0, 0);  chk("sA_t3", 1'b1, 16'h11CD, 1'b0, 2'b00, 8'd5);
    step(K_RD, 1, 8);   chk("sA_t4", 1'b1, 16'h2222, 1'b0, 2'b00, 8'd5);
    step(K_NOP, 0, 0);  chk("sA_t5", 1'b1, 16'h3333, 1'b0, 2'b00, 8'd5);
    step(K_NOP, 0, 0);  chk("sA_t6", 1'b1, 16'h4444, 1'b0, 2'b00, 8'd5);
    step(K_NOP, 0, 0);  chk("sA_t7_gapless", 1'b1, 16'h11CD, 1'b0, 2'b00, 8'd5);
    dq_in = 16'h5A5A;
    step(K_WR, 1, 8);   chk("sA_t8_wr_turn", 1'b1, 16'h2222, 1'b1, 2'b11, 8'd6);
    dq_in = '0;
    step(K_NOP, 0, 0);  chk("sA_t9", 1'b1, 16'h3333, 1'b0, 2'b00, 8'd6);
    step(K_NOP, 0, 0);  chk("sA_t10", 1'b1, 16'h4444, 1'b0, 2'b00, 8'd6);
    step(K_NOP, 0, 0);  chk("sA_t11", 1'b0, 16'h0, 1'b0, 2'b00, 8'd6);

    // ---- reset mid-burst, then read back through cleared written flags ----
    step(K_RD, 1, 8);   chk("sB_t0", 1'b0, 16'h0, 1'b0, 2'b00, 8'd6);
    step(K_NOP, 0, 0);  chk("sB_t1", 1'b0, 16'h0, 1'b0, 2'b00, 8'd6);
    step(K_NOP, 0, 0);  chk("sB_t2", 1'b0, 16'h0, 1'b0, 2'b00, 8'd6);
    step(K_NOP, 0, 0);  chk("sB_t3", 1'b1, 16'h11CD, 1'b0, 2'b00, 8'd6);
    reset = 1'b1;
    step(K_NOP, 0, 0);  chk("sB_reset", 1'b0, 16'h0, 1'b0, 2'b00, 8'd0);
    reset = 1'b0;
    step(K_NOP, 0, 0);  chk("sB_aborted", 1'b0, 16'h0, 1'b0, 2'b00, 8'd0);
    step(K_ACT, 1, 5);  chk("sB_act", 1'b0, 16'h0, 1'b0, 2'b00, 8'd0);
    step(K_NOP, 0, 0);  chk("sB_nop", 1'b0, 16'h0, 1'b0, 2'b00, 8'd0);
    step(K_RD, 1, 8);   chk("sB_rd", 1'b0, 16'h0, 1'b0, 2'b00, 8'd0);
    step(K_NOP, 0, 0);  chk("sB_r1", 1'b0, 16'h0, 1'b0, 2'b00, 8'd0);
    step(K_NOP, 0, 0);  chk("sB_r2", 1'b0, 16'h0, 1'b0, 2'b00, 8'd0);
    for (int k = 0; k < 4; k++) begin
      step(K_NOP, 0, 0);
      chk($sformatf("sB_zero_beat%0d", k), 1'b1, 16'h0000, 1'b0, 2'b00, 8'd0);
    end
    step(K_NOP, 0, 0);  chk("sB_end", 1'b0, 16'h0, 1'b0, 2'b00, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ddr2_dram_pipe.md
DDR2_DRAM_PIPE -- requirements
Module: ddr2_dram_pipe

Interface
REQ-001 SHALL have parameter DQ_WIDTH, default 16; data width, multiple of 8.
REQ-002 SHALL have parameter BANK_BITS, default 2; bank count 2**BANK_BITS.
REQ-003 SHALL have parameter ROW_BITS, default 4, and COL_BITS, default 6; stored rows/columns per bank.
REQ-004 SHALL have parameter ADDR_WIDTH, default 13; addr port width, at least ROW_BITS and COL_BITS.
REQ-005 SHALL have parameter CL, default 3 (legal 2..7), and BL, default 4 (legal 4 or 8).
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 Ports:
ck  in  1  clock; all logic on rising edge
reset  in  1  synchronous active-high reset
cke  in  1  clock enable
cs_n, ras_n, cas_n, we_n  in  1 each  command pins
ba  in  BANK_BITS  bank address
addr  in  ADDR_WIDTH  row (ACT) / column (RD, WR); addr[10] = all-banks (PRE)
dq_in  in  DQ_WIDTH  write data
dm  in  DQ_WIDTH/8  active-high byte mask
dq_out  out  DQ_WIDTH  read data
dq_oe  out  1  read data valid / bus drive enable
err_valid  out  1  one-cycle protocol error pulse
err_code  out  2  01 ACT to open bank, 10 access to closed bank, 11 bus conflict
err_count  out  8  saturating count of errors

Function
REQ-008 SHALL register cke into cke_prev; a command SHALL be decoded at edge T only if cke and cke_prev are both 1; otherwise it is a NOP.
REQ-009 SHALL decode {cs_n,ras_n,cas_n,we_n}: 0011 ACT, 0101 RD, 0100 WR, 0010 PRE, others (incl. cs_n=1) NOP with no error.
REQ-010 SHALL hold, per bank, state CLOSED or OPEN plus an open-row register (addr[ROW_BITS-1:0] latched on ACT).
REQ-011 ACT to a CLOSED bank SHALL set it OPEN; ACT to an OPEN bank SHALL be ignored with error 01.
REQ-012 PRE SHALL close bank ba, or all banks if addr[10]=1; PRE to a CLOSED bank is legal.
REQ-013 RD/WR to a CLOSED bank SHALL be ignored with error 10.
REQ-014 Accepted RD/WR SHALL latch bank, open row and column addr[COL_BITS-1:0] at edge T; a later PRE/ACT SHALL NOT alter an in-flight burst.
REQ-015 Burst column for beat k (0..BL-1) SHALL be {col upper bits, (col low log2(BL) bits + k) mod BL} (sequential wrap).
REQ-016 Read beat k SHALL be registered on dq_out with dq_oe=1 from edge T+CL+k until the next edge; dq_oe=0 and dq_out=0 otherwise.
REQ-017 A location never written since reset SHALL read as 0; the per-location written bit is cleared by reset.
REQ-018 Write beat k SHALL be sampled from dq_in at edge T+CL-1+k; a byte lane with dm=1 SHALL keep its old value; the written bit SHALL be set if any lane is written.
REQ-019 RD or WR issued less than BL cycles after the last accepted RD/WR, or WR less than BL+1 cycles after the last accepted RD, SHALL be ignored with error 11.
REQ-020 RD issued exactly BL cycles after an accepted RD SHALL produce 2*BL gapless beats.
REQ-021 Errors SHALL assert err_valid with err_code for the one cycle after edge T; err_count SHALL increment per error and saturate at 255.
REQ-022 At most one command per edge; priorities do not arise.

Reset
REQ-023 On reset at edge R: all banks CLOSED, read/write pipelines flushed, written bits cleared, cke_prev=0, dq_out=0, dq_oe=0, err_valid=0, err_code=0, err_count=0, all effective after edge R.
REQ-024 Reset mid-burst SHALL abort it: no further beats driven or captured; stored data SHALL NOT be cleared otherwise but reads return 0 via written bits.

Verification (CL=3, BL=4, DQ_WIDTH=16)
REQ-025 ACT b1 row5; WR b1 col8 data 1111,2222,3333,4444 (dm=0); RD b1 col8 at T -> dq_out 1111,2222,3333,4444 with dq_oe=1 after edges T+3..T+6.
REQ-026 Same data, RD col10 -> beats 3333,4444,1111,2222 (wrap).
REQ-027 WR col8 beat0 data ABCD, dm=2'b10 -> subsequent read beat0 = 11CD.
REQ-028 RD to CLOSED bank 2 -> err_valid one cycle, err_code=10, err_count=1, dq_oe stays 0; ACT with cke_prev=0 -> ignored, no error.
REQ-029 RD at T, RD at T+2 -> second rejected, err_code=11; RD at T+4 -> 8 gapless beats T+3..T+10.
REQ-030 Reset at T+4 during read started at T -> dq_oe=0 after T+4; RD after re-ACT of same row returns 0000.
